alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Initiator/controller for the 32-bit combinational ALU: accepts an operation request over a valid/ready handshake and drives the ALU operands and 3-bit ALUop.
- Captures the ALU result, zero and overflow flags and returns them over a second valid/ready handshake.
- Adds a multicycle 32x32 -> low-32 multiply built from iterated ALU additions, so the datapath gets MUL without a dedicated multiplier.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU instance.
- ALUOP_W, 3, ALU operation select width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_cmd  in  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 MUL, 6/7 illegal
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- alu_a  out  WIDTH  to ALU a
- alu_b  out  WIDTH  to ALU b
- alu_op  out  ALUOP_W  to ALU ALUop: AND=000, OR=001, ADD=010, SUB=110, SLT=111
- alu_result  in  WIDTH  from ALU result
- alu_zero  in  1  from ALU zero
- alu_overflow  in  1  from ALU overflow
- out_valid  out  1  response valid
- out_ready  in  1  response consumed when out_valid & out_ready
- out_result  out  WIDTH  captured result
- out_zero  out  1  result == 0
- out_overflow  out  1  signed overflow (ADD/SUB only)
- out_illegal  out  1  in_cmd was 6 or 7

Behaviour:
- Reset (async, immediate): state IDLE; out_valid=0; out_result=0; out_zero=0; out_overflow=0; out_illegal=0; internal registers cleared. alu_a, alu_b and alu_op are 0 while in IDLE.
- Reset mid-operation abandons the operation; no response is produced.
- States: IDLE, EXEC, MUL, DONE.
- in_ready=1 only in IDLE. There is no request/response overlap.
- IDLE: on accept, register cmd, a and b. Go to MUL if cmd=5, else go to EXEC.
- EXEC (exactly 1 cycle):
  - Drive alu_a=a_reg, alu_b=b_reg, alu_op per the table.
  - Capture out_result=alu_result and out_zero=alu_zero.
  - out_overflow=alu_overflow for ADD/SUB, 0 for AND/OR/SLT.
  - Go to DONE.
- Illegal cmd in EXEC: ALU outputs ignored; out_result=0, out_zero=1, out_overflow=0, out_illegal=1.
- MUL init on accept: acc=0, mcand=a, mplier=b, count=0.
- MUL, each cycle:
  - Drive alu_op=ADD, alu_a=acc, alu_b = mplier[0] ? mcand : 0.
  - Update acc<=alu_result, mcand<<=1, mplier>>=1, count++.
  - Exit to DONE when (mplier>>1)==0 or count==31.
  - On exit: out_result=final sum, out_zero=(final sum==0), out_overflow=0, out_illegal=0.
  - Bits above 32 are discarded. Result equals (a*b) mod 2^32 for both signed and unsigned interpretations.
- DONE:
  - out_valid=1. Out registers are held stable while out_ready=0.
  - On out_ready: out_valid=0 next cycle and state IDLE; in_ready=1 that same next cycle.
- Latency from the accept edge to out_valid: EXEC ops 2 cycles. MUL is 1+max(1, msb_index(b)+1) cycles: b=0 or b=1 gives 2, b=0x80000000 gives 33.
- Throughput: at best one operation every 3 cycles (EXEC op with out_ready held high).
- ALUop width/encoding is fixed; ALU binvert/carry-in is derived inside the ALU from alu_op.

Decomposition:
- Shared package holds:
  - ALUop constants ALUOP_AND/OR/ADD/SUB/SLT.
  - Command constants CMD_AND..CMD_MUL.
  - State encoding.
  - WIDTH default.
- One natural sub-module, alu_cmd_decode (combinational cmd -> alu_op, is_mul, is_illegal, ovf_enable).
- The ALU itself is instantiated outside; the bench connects the real ALU to alu_* ports.

Test Plan:
- Reset asserted mid-MUL (a=7, b=0xFFFF): out_valid drops to 0 immediately and stays 0. After release, in_ready=1 and a new ADD 1+1 returns 2 normally.
- ADD a=0x7FFFFFFF, b=1 -> out_result=0x80000000, out_overflow=1, out_zero=0, out_valid 2 cycles after accept.
- SUB a=5, b=5 -> result 0, out_zero=1, overflow 0. SLT a=0xFFFFFFFF(-1), b=1 -> result 1.
- MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> result 1 after 33 cycles. MUL a=1234, b=0 -> result 0, out_zero=1, latency 2.
- Back-pressure: OR a=0xF0, b=0x0F with out_ready=0 for 5 cycles -> out_valid and result 0xFF held stable, in_ready=0. out_ready=1 -> in_ready=1 next cycle.
- in_cmd=7 -> out_illegal=1, out_result=0, out_zero=1, out_overflow=0. The following ADD clears out_illegal.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared constants and state encoding for the ALU sequencer
package alu_sequencer_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int ALUOP_W_DEF = 3;

    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_ADD = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b110;
    localparam logic [2:0] ALUOP_SLT = 3'b111;

    localparam logic [2:0] CMD_AND = 3'd0;
    localparam logic [2:0] CMD_OR  = 3'd1;
    localparam logic [2:0] CMD_ADD = 3'd2;
    localparam logic [2:0] CMD_SUB = 3'd3;
    localparam logic [2:0] CMD_SLT = 3'd4;
    localparam logic [2:0] CMD_MUL = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_cmd_decode.sv
// rtl/alu_cmd_decode.sv - combinational command to ALUop / class decode
module alu_cmd_decode
    import alu_sequencer_pkg::*;
(
    input  logic [2:0] cmd,
    output logic [2:0] alu_op,
    output logic       is_mul,
    output logic       is_illegal,
    output logic       ovf_enable
);

    always_comb begin
        alu_op     = ALUOP_AND;
        is_mul     = 1'b0;
        is_illegal = 1'b0;
        ovf_enable = 1'b0;
        case (cmd)
            CMD_AND: alu_op = ALUOP_AND;
            CMD_OR:  alu_op = ALUOP_OR;
            CMD_ADD: begin
                alu_op     = ALUOP_ADD;
                ovf_enable = 1'b1;
            end
            CMD_SUB: begin
                alu_op     = ALUOP_SUB;
                ovf_enable = 1'b1;
            end
            CMD_SLT: alu_op = ALUOP_SLT;
            CMD_MUL: begin
                alu_op = ALUOP_ADD;
                is_mul = 1'b1;
            end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response controller for an external ALU with shift-add multiply
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_cmd,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [ALUOP_W-1:0] alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    input  logic               alu_overflow,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic               out_overflow,
    output logic               out_illegal
);

    state_t             state, state_next;
    logic [2:0]         cmd_reg;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc;
    logic [4:0]         count;
    logic [WIDTH-1:0]   mplier_next;
    logic               mul_done;
    logic [2:0]         dec_cmd;
    logic [2:0]         dec_alu_op;
    logic               dec_is_mul;
    logic               dec_is_illegal;
    logic               dec_ovf_enable;

    // In IDLE the decoder looks at the incoming command to pick EXEC vs MUL;
    // afterwards it decodes the captured command.
    assign dec_cmd = (state == ST_IDLE) ? in_cmd : cmd_reg;

    alu_cmd_decode u_decode (
        .cmd        (dec_cmd),
        .alu_op     (dec_alu_op),
        .is_mul     (dec_is_mul),
        .is_illegal (dec_is_illegal),
        .ovf_enable (dec_ovf_enable)
    );

    assign mplier_next = mplier >> 1;
    assign mul_done    = (mplier_next == '0) || (count == 5'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid) state_next = dec_is_mul ? ST_MUL : ST_EXEC;
            ST_EXEC: state_next = ST_DONE;
            ST_MUL:  if (mul_done) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_EXEC: begin
                alu_a  = mcand;
                alu_b  = mplier;
                alu_op = dec_alu_op;
            end
            ST_MUL: begin
                alu_a  = acc;
                alu_b  = mplier[0] ? mcand : '0;
                alu_op = ALUOP_ADD;
            end
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // mcand/mplier double as the EXEC operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_reg      <= '0;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            count        <= '0;
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_illegal  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    cmd_reg <= in_cmd;
                    mcand   <= in_a;
                    mplier  <= in_b;
                    acc     <= '0;
                    count   <= '0;
                end
                ST_EXEC: begin
                    if (dec_is_illegal) begin
                        out_result   <= '0;
                        out_zero     <= 1'b1;
                        out_overflow <= 1'b0;
                        out_illegal  <= 1'b1;
                    end else begin
                        out_result   <= alu_result;
                        out_zero     <= alu_zero;
                        out_overflow <= dec_ovf_enable & alu_overflow;
                        out_illegal  <= 1'b0;
                    end
                end
                ST_MUL: begin
                    acc    <= alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    count  <= count + 5'd1;
                    if (mul_done) begin
                        out_result   <= alu_result;
                        out_zero     <= (alu_result == '0);
                        out_overflow <= 1'b0;
                        out_illegal  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed scoreboard bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_cmd;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_op;
    logic [W-1:0]  alu_result;
    logic          alu_zero;
    logic          alu_overflow;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_zero;
    logic          out_overflow;
    logic          out_illegal;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_sequencer #(.WIDTH(W), .ALUOP_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cmd       (in_cmd),
        .in_a         (in_a),
        .in_b         (in_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    // Behavioural 32-bit ALU
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b110: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b111: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: ;
        endcase
        alu_zero = (alu_result == '0);
    end

    function automatic exp_t model(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb_, s;
        logic [63:0] p;
        int          msb;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        e.res = '0; e.ov = 1'b0; e.ill = 1'b0; e.lat = 2;
        case (cmd)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: begin s = sa + sb_; e.res = s[31:0]; e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd3: begin s = sa - sb_; e.res = s[31:0]; e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd4: e.res = (sa < sb_) ? 32'd1 : 32'd0;
            3'd5: begin
                p = {32'd0, a} * {32'd0, b};
                e.res = p[31:0];
                msb = -1;
                for (int i = 0; i < 32; i++) if (b[i]) msb = i;
                e.lat = 1 + ((msb + 1 > 1) ? msb + 1 : 1);
            end
            default: begin e.res = '0; e.ill = 1'b1; end
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        exp_t e;
        int   lat;
        sb.push_back(model(cmd, a, b));
        chk({tag, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_cmd = cmd; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, " latency"}, 32'(lat), 32'(e.lat));
        chk({tag, " result"}, out_result, e.res);
        chk({tag, " zero"}, {31'd0, out_zero}, {31'd0, e.z});
        chk({tag, " overflow"}, {31'd0, out_overflow}, {31'd0, e.ov});
        chk({tag, " illegal"}, {31'd0, out_illegal}, {31'd0, e.ill});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, " hold_result"}, out_result, e.res);
            chk({tag, " hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic saw_valid;
        rst = 1'b1; in_valid = 1'b0; in_cmd = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_result", out_result, 32'd0);
        chk("reset out_illegal", {31'd0, out_illegal}, 32'd0);
        chk("reset alu_op", {29'd0, alu_op}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle in_ready", {31'd0, in_ready}, 32'd1);

        run_op("add_ovf", 3'd2, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op("sub_zero", 3'd3, 32'd5, 32'd5, 0);
        run_op("slt_neg", 3'd4, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("mul_ff", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mul_b0", 3'd5, 32'd1234, 32'd0, 0);
        run_op("mul_b1", 3'd5, 32'd99, 32'd1, 0);
        run_op("mul_msb", 3'd5, 32'd5, 32'h8000_0000, 0);
        run_op("or_bp", 3'd1, 32'h0000_00F0, 32'h0000_000F, 5);
        run_op("illegal7", 3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op("add_clr", 3'd2, 32'd3, 32'd4, 0);
        run_op("illegal6", 3'd6, 32'd1, 32'd1, 1);
        run_op("and", 3'd0, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 0);
        for (int i = 0; i < 3; i++)
            run_op("mul_rand", 3'd5, $urandom, $urandom_range(0, 32'h000F_FFFF), 0);
        run_op("sub_ovf", 3'd3, 32'h8000_0000, 32'd1, 0);

        in_valid = 1'b1; in_cmd = 3'd5; in_a = 32'd7; in_b = 32'h0000_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("rst_mid out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid out_result", out_result, 32'd0);
        chk("rst_mid alu_a", alu_a, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("rst_mid no_response", {31'd0, saw_valid}, 32'd0);
        run_op("add_after_rst", 3'd2, 32'd1, 32'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
